// File: rtl/upsample2d.sv
// Streaming 2x nearest-neighbour upsampler: each input pixel is emitted twice
// per row, and each row is replayed from a one-line buffer.
module upsample2d #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIDTH  = 208
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8:0]            i_width,
  input  logic [8:0]            i_height,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_done
);

  localparam int XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ROW_A, ROW_B} state_t;

  state_t                state_q, state_d;
  logic [8:0]            w_q, w_d, h_q, h_d, y_q, y_d;
  logic [XW-1:0]         x_q, x_d, x_nxt;
  logic                  rep_q, rep_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] buf_q [MAX_WIDTH];
  logic                  buf_we;
  logic [XW-1:0]         buf_wa;
  logic                  last_x, last_y, beat, accept, bad_cfg;

  assign x_nxt   = x_q + XW'(1);
  assign last_x  = (9'(x_q) == (w_q - 9'd1));
  assign last_y  = (y_q == (h_q - 9'd1));
  assign beat    = valid_q & i_ready;
  assign bad_cfg = (i_width == '0) | (i_height == '0) | (i_width > 9'(MAX_WIDTH));

  // The last beat of a row is the ROW_B preload cycle, so no accept then.
  assign o_ready = (state_q == ROW_A) & (~valid_q | (rep_q & i_ready & ~last_x));
  assign accept  = i_valid & o_ready;

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    rep_d   = rep_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    buf_we  = accept;
    // An accept alongside a rep==1 beat stores the pixel for the next column.
    buf_wa  = valid_q ? x_nxt : x_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (i_start) begin
          if (bad_cfg) begin
            done_d = 1'b1;
          end else begin
            w_d     = i_width;
            h_d     = i_height;
            x_d     = '0;
            y_d     = '0;
            rep_d   = 1'b0;
            state_d = ROW_A;
          end
        end
      end
      ROW_A: begin
        if (beat && !rep_q) begin
          rep_d = 1'b1;
        end else if (beat) begin
          rep_d = 1'b0;
          if (last_x) begin
            x_d     = '0;
            data_d  = buf_q[0];
            valid_d = 1'b1;
            state_d = ROW_B;
          end else begin
            x_d     = x_nxt;
            valid_d = accept;
            if (accept) data_d = i_data;
          end
        end else if (accept) begin
          valid_d = 1'b1;
          data_d  = i_data;
          rep_d   = 1'b0;
        end
      end
      ROW_B: begin
        if (beat && !rep_q) begin
          rep_d = 1'b1;
        end else if (beat) begin
          rep_d = 1'b0;
          if (!last_x) begin
            x_d    = x_nxt;
            data_d = buf_q[x_nxt];
          end else if (last_y) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            y_d     = y_q + 9'd1;
            x_d     = '0;
            valid_d = 1'b0;
            state_d = ROW_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rep_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) buf_q[buf_wa] <= i_data;
  end

endmodule

// File: tb/tb_upsample2d.sv
// Directed self-checking bench for upsample2d.
module tb_upsample2d;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_width = '0;
  logic [8:0]  i_height = '0;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_done;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;
  logic [15:0] in_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  upsample2d #(.DATA_WIDTH(16), .MAX_WIDTH(208)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_width(i_width),
    .i_height(i_height), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_done(o_done)
  );

  function automatic void build_exp(input int w, input int h);
    exp_q.delete();
    for (int y = 0; y < h; y++)
      for (int r = 0; r < 2; r++)
        for (int x = 0; x < w; x++)
          for (int k = 0; k < 2; k++)
            exp_q.push_back(in_q[y*w + x]);
  endfunction

  task automatic do_start(input int w, input int h);
    @(negedge clk);
    i_start = 1'b1; i_width = 9'(w); i_height = 9'(h);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Drives the frame from in_q and records beats until o_done or budget expiry.
  task automatic run_frame(input bit rnd, input int budget,
                           output int last_beat_c, output int done_c);
    int idx;
    logic hold;
    logic [15:0] hold_d;
    idx = 0; hold = 1'b0; hold_d = '0; last_beat_c = -1; done_c = -1;
    got_q.delete();
    for (int c = 0; c < budget && done_c < 0; c++) begin
      @(negedge clk);
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < in_q.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
        i_valid = 1'b1; i_data = in_q[idx];
      end else begin
        i_valid = 1'b0; i_data = 16'($urandom);
      end
      #1;
      if (hold) begin
        vectors++;
        if (o_valid !== 1'b1 || o_data !== hold_d) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%b data=%h, want valid=1 data=%h",
                   o_valid, o_data, hold_d);
        end
      end
      hold = o_valid & ~i_ready;
      hold_d = o_data;
      if (o_valid && i_ready) begin got_q.push_back(o_data); last_beat_c = c; end
      if (i_valid && o_ready) idx++;
      if (o_done) done_c = c;
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0;
    accepted = idx;
  endtask

  task automatic test_reset;
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors += 4;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    if (o_data !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", o_data); end
    if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", o_done); end
    if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    i_rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] exp1 [16] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
    int lb, dc;
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_start(2, 2);
    run_frame(1'b0, 200, lb, dc);
    vectors += 2;
    if (got_q.size() != 16) begin miscompares++; $display("FAIL t1_count: got %0d want 16", got_q.size()); end
    if (dc < 0 || dc != lb + 1) begin miscompares++; $display("FAIL t1_done_timing: got done@%0d want %0d", dc, lb + 1); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp1[i]) begin miscompares++; $display("FAIL t1_beat%0d: got %h want %h", i, got_q[i], exp1[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp1 [16] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
    int lb, dc;
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_start(2, 2);
    run_frame(1'b1, 1000, lb, dc);
    vectors += 2;
    if (got_q.size() != 16) begin miscompares++; $display("FAIL t2_count: got %0d want 16", got_q.size()); end
    if (dc < 0) begin miscompares++; $display("FAIL t2_done: got none want pulse"); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp1[i]) begin miscompares++; $display("FAIL t2_beat%0d: got %h want %h", i, got_q[i], exp1[i]); end
    end
  endtask

  task automatic test_max_width;
    int lb, dc, bad;
    in_q.delete();
    for (int i = 0; i < 416; i++) in_q.push_back(16'(i));
    build_exp(208, 2);
    do_start(208, 2);
    run_frame(1'b0, 5000, lb, dc);
    vectors += 4;
    if (got_q.size() != 1664) begin miscompares++; $display("FAIL t3_count: got %0d want 1664", got_q.size()); end
    if (accepted != 416) begin miscompares++; $display("FAIL t3_accepts: got %0d want 416", accepted); end
    if (dc < 0 || dc != lb + 1) begin miscompares++; $display("FAIL t3_done_timing: got done@%0d want %0d", dc, lb + 1); end
    if (got_q.size() > 831 && got_q[830] !== 16'd207) begin
      miscompares++; $display("FAIL t3_buf207: got %h want 00cf", got_q[830]);
    end
    bad = 0;
    for (int i = 0; i < 1664 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        if (bad < 5) $display("FAIL t3_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
        bad++;
      end
    end
  endtask

  task automatic test_reject;
    int cfg [3][2] = '{'{0, 2}, '{209, 1}, '{2, 0}};
    for (int k = 0; k < 3; k++) begin
      do_start(cfg[k][0], cfg[k][1]);
      #1;
      vectors += 3;
      if (o_done !== 1'b1) begin miscompares++; $display("FAIL t4_done%0d: got %b want 1", k, o_done); end
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL t4_valid%0d: got %b want 0", k, o_valid); end
      if (o_ready !== 1'b0) begin miscompares++; $display("FAIL t4_ready%0d: got %b want 0", k, o_ready); end
      @(negedge clk); #1;
      vectors += 2;
      if (o_done !== 1'b0) begin miscompares++; $display("FAIL t4_pulse%0d: got %b want 0", k, o_done); end
      if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
        miscompares++; $display("FAIL t4_idle%0d: got valid=%b ready=%b want 0 0", k, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_signed;
    int lb, dc;
    in_q = '{16'h8000};
    do_start(1, 1);
    run_frame(1'b0, 100, lb, dc);
    vectors += 2;
    if (got_q.size() != 4) begin miscompares++; $display("FAIL t5_count: got %0d want 4", got_q.size()); end
    if (dc < 0 || dc != lb + 1) begin miscompares++; $display("FAIL t5_done_timing: got done@%0d want %0d", dc, lb + 1); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== 16'h8000) begin miscompares++; $display("FAIL t5_beat%0d: got %h want 8000", i, got_q[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] exp6 [8] = '{5,5,6,6,5,5,6,6};
    int idx, lb, dc;
    bit spurious;
    in_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    got_q.delete();
    idx = 0;
    do_start(2, 2);
    // Five beats in means the row replay has started.
    for (int c = 0; c < 100 && got_q.size() < 5; c++) begin
      @(negedge clk);
      i_ready = 1'b1;
      i_valid = (idx < in_q.size());
      i_data = (idx < in_q.size()) ? in_q[idx] : 16'h0;
      #1;
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (i_valid && o_ready) idx++;
    end
    vectors++;
    if (got_q.size() != 5) begin miscompares++; $display("FAIL t6_reach_rowb: got %0d beats want 5", got_q.size()); end
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    vectors += 3;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL t6_valid: got %b want 0", o_valid); end
    if (o_ready !== 1'b0) begin miscompares++; $display("FAIL t6_ready: got %b want 0", o_ready); end
    if (o_done !== 1'b0) begin miscompares++; $display("FAIL t6_done: got %b want 0", o_done); end
    spurious = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (o_done || o_valid) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin miscompares++; $display("FAIL t6_quiet: got activity after reset want none"); end
    in_q = '{16'd5, 16'd6};
    do_start(2, 1);
    run_frame(1'b0, 200, lb, dc);
    vectors += 2;
    if (got_q.size() != 8) begin miscompares++; $display("FAIL t6_count: got %0d want 8", got_q.size()); end
    if (dc < 0 || dc != lb + 1) begin miscompares++; $display("FAIL t6_done_timing: got done@%0d want %0d", dc, lb + 1); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp6[i]) begin miscompares++; $display("FAIL t6_beat%0d: got %h want %h", i, got_q[i], exp6[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_max_width();
    test_reject();
    test_signed();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
